rf_wb_arbiter: RTL and testbench

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

---
 rtl/rf_wb_arbiter.sv | 154 +++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: merges single-cycle ALU results with a
// FIFO of long-unit results onto one write port and tracks pending
// long-unit destinations in a 32-entry busy scoreboard.
module rf_wb_arbiter #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_stall,
  input  logic        lu_valid,
  input  logic [4:0]  lu_rd,
  input  logic [31:0] lu_data,
  output logic        lu_ready,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  q_rs1,
  input  logic [4:0]  q_rs2,
  output logic        q_busy1,
  output logic        q_busy2,
  output logic        rf_regwrite,
  output logic [4:0]  rf_writereg,
  output logic [31:0] rf_writedata
);

  localparam int unsigned RW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  // FIFO storage and control
  logic [RW-1:0] r_fifo_rd   [DEPTH];
  logic [DW-1:0] r_fifo_data [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  // Write port and scoreboard state
  logic          r_regwrite;
  logic [RW-1:0] r_writereg;
  logic [DW-1:0] r_writedata;
  logic          r_from_fifo;
  logic [31:0]   r_busy;

  logic          w_full;
  logic          w_empty;
  logic          w_lu_ready;
  logic          w_push;
  logic          w_pop;
  logic          w_grant_alu;
  logic          w_alu_stall;
  logic          w_grant;
  logic [RW-1:0] w_wb_rd;
  logic [DW-1:0] w_wb_data;
  logic [31:0]   w_busy_nxt;

  // Pointer advance with wrap at DEPTH (DEPTH need not be a power of two)
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_full     = (r_count == CW'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_lu_ready = (r_count < CW'(DEPTH)) && rst;
  assign w_push     = lu_valid && w_lu_ready;

  // Fixed-priority grant: full FIFO drains first, then ALU, then FIFO
  always_comb begin
    w_pop       = 1'b0;
    w_grant_alu = 1'b0;
    w_alu_stall = 1'b0;
    if (rst) begin
      if (w_full) begin
        w_pop       = 1'b1;
        w_alu_stall = alu_valid;
      end else if (alu_valid) begin
        w_grant_alu = 1'b1;
      end else if (!w_empty) begin
        w_pop       = 1'b1;
      end
    end
  end

  assign w_grant   = w_grant_alu || w_pop;
  assign w_wb_rd   = w_grant_alu ? alu_rd   : r_fifo_rd[r_rptr];
  assign w_wb_data = w_grant_alu ? alu_data : r_fifo_data[r_rptr];

  // FIFO payload write; contents are don't-care until pushed
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_rd[r_wptr]   <= lu_rd;
      r_fifo_data[r_wptr] <= lu_data;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)  r_rptr <= ptr_inc(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Write-port register; x0 grants complete but never assert the enable
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_regwrite  <= 1'b0;
      r_writereg  <= '0;
      r_writedata <= '0;
      r_from_fifo <= 1'b0;
    end else begin
      r_regwrite  <= w_grant && (w_wb_rd != '0);
      r_from_fifo <= w_pop;
      if (w_grant) begin
        r_writereg  <= w_wb_rd;
        r_writedata <= w_wb_data;
      end
    end
  end

  // Scoreboard update: FIFO writeback clears, issue sets (set wins)
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_regwrite && r_from_fifo) w_busy_nxt[r_writereg] = 1'b0;
    if (issue_valid && (issue_rd != '0)) w_busy_nxt[issue_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk) begin
    if (!rst) r_busy <= '0;
    else      r_busy <= w_busy_nxt;
  end

  assign alu_stall    = w_alu_stall;
  assign lu_ready     = w_lu_ready;
  assign q_busy1      = r_busy[q_rs1];
  assign q_busy2      = r_busy[q_rs2];
  assign rf_regwrite  = r_regwrite;
  assign rf_writereg  = r_writereg;
  assign rf_writedata = r_writedata;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter (DEPTH = 2).
module tb_rf_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_stall;
  logic        lu_valid;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  q_rs1;
  logic [4:0]  q_rs2;
  logic        q_busy1;
  logic        q_busy2;
  logic        rf_regwrite;
  logic [4:0]  rf_writereg;
  logic [31:0] rf_writedata;

  int errors = 0;
  int checks = 0;

  rf_wb_arbiter #(.DEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .alu_valid    (alu_valid),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .alu_stall    (alu_stall),
    .lu_valid     (lu_valid),
    .lu_rd        (lu_rd),
    .lu_data      (lu_data),
    .lu_ready     (lu_ready),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .q_rs1        (q_rs1),
    .q_rs2        (q_rs2),
    .q_busy1      (q_busy1),
    .q_busy2      (q_busy2),
    .rf_regwrite  (rf_regwrite),
    .rf_writereg  (rf_writereg),
    .rf_writedata (rf_writedata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; registered outputs are stable here
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Let combinational outputs settle after an input change
  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b0; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lu_valid = 1'b0; lu_rd = '0; lu_data = '0;
    issue_valid = 1'b0; issue_rd = '0; q_rs1 = 5'd7; q_rs2 = 5'd0;

    // Reset behaviour: no ready, no stall, cleared write port
    tick(); tick();
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h3;
    settle();
    check("rst_lu_ready", 32'(lu_ready), 32'd0);
    check("rst_alu_stall", 32'(alu_stall), 32'd0);
    tick();
    check("rst_regwrite", 32'(rf_regwrite), 32'd0);
    check("rst_writereg", 32'(rf_writereg), 32'd0);
    check("rst_writedata", rf_writedata, 32'd0);
    check("rst_busy", 32'(q_busy1), 32'd0);

    // Release; first ALU write
    rst = 1'b1; alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
    settle();
    check("rel_lu_ready", 32'(lu_ready), 32'd1);
    check("alu_stall_empty", 32'(alu_stall), 32'd0);
    tick();
    check("alu_regwrite", 32'(rf_regwrite), 32'd1);
    check("alu_writereg", 32'(rf_writereg), 32'd5);
    check("alu_writedata", rf_writedata, 32'h1234);

    // Issue rd 7; busy not visible same cycle
    issue_valid = 1'b1; issue_rd = 5'd7; alu_rd = 5'd3; alu_data = 32'h33;
    settle();
    check("busy_no_bypass", 32'(q_busy1), 32'd0);
    tick();
    issue_valid = 1'b0;
    lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 32'hAA;
    alu_rd = 5'd4; alu_data = 32'h44;
    settle();
    check("busy7_set", 32'(q_busy1), 32'd1);
    check("lu_ready_push", 32'(lu_ready), 32'd1);
    tick();
    lu_valid = 1'b0;
    check("alu_over_fifo", 32'(rf_writereg), 32'd4);
    tick();
    tick();
    check("fifo_held_busy", 32'(q_busy1), 32'd1);
    check("fifo_held_reg", 32'(rf_writereg), 32'd4);
    alu_valid = 1'b0;
    tick();
    check("lu_regwrite", 32'(rf_regwrite), 32'd1);
    check("lu_writereg", 32'(rf_writereg), 32'd7);
    check("lu_writedata", rf_writedata, 32'hAA);
    check("busy7_pre_clear", 32'(q_busy1), 32'd1);
    tick();
    check("idle_regwrite", 32'(rf_regwrite), 32'd0);
    check("idle_hold_reg", 32'(rf_writereg), 32'd7);
    check("idle_hold_data", rf_writedata, 32'hAA);
    check("busy7_cleared", 32'(q_busy1), 32'd0);

    // Fill DEPTH=2 FIFO while ALU holds the port
    lu_valid = 1'b1; lu_rd = 5'd10; lu_data = 32'h100;
    alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 32'h111;
    tick();
    lu_rd = 5'd12; lu_data = 32'h200;
    settle();
    check("fill_lu_ready", 32'(lu_ready), 32'd1);
    check("fill_alu_stall", 32'(alu_stall), 32'd0);
    tick();
    lu_valid = 1'b0;
    settle();
    check("full_lu_ready", 32'(lu_ready), 32'd0);
    check("full_alu_stall", 32'(alu_stall), 32'd1);
    tick();
    check("full_pop_reg", 32'(rf_writereg), 32'd10);
    check("full_pop_data", rf_writedata, 32'h100);
    check("full_pop_we", 32'(rf_regwrite), 32'd1);
    check("after_pop_ready", 32'(lu_ready), 32'd1);
    check("after_pop_stall", 32'(alu_stall), 32'd0);
    tick();
    check("alu_after_full_reg", 32'(rf_writereg), 32'd11);
    check("alu_after_full_data", rf_writedata, 32'h111);
    alu_valid = 1'b0;
    tick();
    check("drain_reg", 32'(rf_writereg), 32'd12);
    check("drain_data", rf_writedata, 32'h200);

    // x0 grants: handshakes complete, no write enable
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEAD;
    tick();
    check("x0_alu_we", 32'(rf_regwrite), 32'd0);
    alu_valid = 1'b0;
    lu_valid = 1'b1; lu_rd = 5'd0; lu_data = 32'h55;
    issue_valid = 1'b1; issue_rd = 5'd0;
    tick();
    lu_valid = 1'b0; issue_valid = 1'b0;
    check("x0_busy0", 32'(q_busy2), 32'd0);
    tick();
    check("x0_lu_we", 32'(rf_regwrite), 32'd0);

    // Set wins over same-edge clear
    q_rs1 = 5'd9;
    issue_valid = 1'b1; issue_rd = 5'd9;
    tick();
    issue_valid = 1'b0;
    lu_valid = 1'b1; lu_rd = 5'd9; lu_data = 32'h99;
    tick();
    lu_valid = 1'b0;
    tick();
    check("b9_we", 32'(rf_regwrite), 32'd1);
    check("b9_reg", 32'(rf_writereg), 32'd9);
    issue_valid = 1'b1; issue_rd = 5'd9;
    tick();
    issue_valid = 1'b0;
    check("set_wins", 32'(q_busy1), 32'd1);

    // Full FIFO (proves x0 entry was popped), then reset mid-flight
    lu_valid = 1'b1; lu_rd = 5'd13; lu_data = 32'h13;
    alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'h2020;
    tick();
    lu_rd = 5'd14; lu_data = 32'h14;
    tick();
    lu_valid = 1'b0;
    settle();
    check("pre_rst_full", 32'(lu_ready), 32'd0);
    rst = 1'b0;
    settle();
    check("in_rst_stall", 32'(alu_stall), 32'd0);
    tick();
    check("mid_rst_we", 32'(rf_regwrite), 32'd0);
    check("mid_rst_reg", 32'(rf_writereg), 32'd0);
    check("mid_rst_data", rf_writedata, 32'd0);
    check("mid_rst_busy", 32'(q_busy1), 32'd0);
    rst = 1'b1; alu_valid = 1'b0;
    settle();
    check("post_rst_ready", 32'(lu_ready), 32'd1);
    tick();
    check("no_stale_1", 32'(rf_regwrite), 32'd0);
    tick();
    check("no_stale_2", 32'(rf_regwrite), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
